// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline-stage registers: default bundle
// widths, control bit positions, state encoding and EX/MEM bundle helpers.
package pipe_pkg;

   localparam int XLEN    = 32;
   localparam int REG_W   = 5;
   localparam int CTRL_W  = 4;
   localparam int EXMEM_W = 4 * XLEN + REG_W;

   localparam int REGWRITE     = 3;
   localparam int RESULTSRC_HI = 2;
   localparam int RESULTSRC_LO = 1;
   localparam int MEMWRITE     = 0;

   localparam logic [1:0] ST_EMPTY = 2'b00;
   localparam logic [1:0] ST_FULL  = 2'b01;
   localparam logic [1:0] ST_SKID  = 2'b10;

   typedef struct packed {
      logic [XLEN-1:0]  alu_result;
      logic [XLEN-1:0]  write_data;
      logic [XLEN-1:0]  imm_ext;
      logic [XLEN-1:0]  pc_plus4;
      logic [REG_W-1:0] rd;
   } exmem_t;

   function automatic logic [EXMEM_W-1:0] pack_exmem(input exmem_t bundle);
      return bundle;
   endfunction

   function automatic exmem_t unpack_exmem(input logic [EXMEM_W-1:0] flat);
      return exmem_t'(flat);
   endfunction

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
// Shared by the pipeline stages (stall count) and the hazard unit perf counters.
module pipe_sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] count
);

   logic at_max;

   assign at_max = (count == {CNT_W{1'b1}});

   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && !at_max) begin
         count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/pipe_stage_elastic.sv
// Generic inter-stage register with valid/ready handshake, optional 2-entry
// skid buffer, synchronous flush to a bubble and a saturating stall counter.
module pipe_stage_elastic
   import pipe_pkg::*;
#(
   parameter int DATA_W = pipe_pkg::EXMEM_W,
   parameter int CTRL_W = pipe_pkg::CTRL_W,
   parameter int SKID   = 1,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   output logic [CNT_W-1:0]  stall_cnt,
   input  logic              stall_clr
);

   logic              in_fire;
   logic              out_fire;
   logic              m_valid;
   logic [CTRL_W-1:0] m_ctrl;
   logic [DATA_W-1:0] m_data;

   assign in_fire   = in_valid & in_ready;
   assign out_fire  = m_valid & out_ready;
   assign out_valid = m_valid;
   assign out_ctrl  = m_ctrl & {CTRL_W{m_valid}};
   assign out_data  = m_data;

   generate
      if (SKID != 0) begin : g_skid
         logic [1:0]        state_q, state_d;
         logic [CTRL_W-1:0] m_ctrl_q, m_ctrl_d;
         logic [DATA_W-1:0] m_data_q, m_data_d;
         logic [CTRL_W-1:0] s_ctrl_q, s_ctrl_d;
         logic [DATA_W-1:0] s_data_q, s_data_d;
         logic              in_ready_q;

         // NOTE: every output of this block gets a hold value first, so no
         // path through the case leaves a signal unassigned and no latch forms.
         always_comb begin
            state_d  = state_q;
            m_ctrl_d = m_ctrl_q;
            m_data_d = m_data_q;
            s_ctrl_d = s_ctrl_q;
            s_data_d = s_data_q;
            if (flush) begin
               state_d  = ST_EMPTY;
               m_ctrl_d = '0;
               s_ctrl_d = '0;
            end else begin
               case (state_q)
                  ST_EMPTY: begin
                     if (in_fire) begin
                        m_ctrl_d = in_ctrl;
                        m_data_d = in_data;
                        state_d  = ST_FULL;
                     end
                  end
                  ST_FULL: begin
                     if (in_fire && out_fire) begin
                        m_ctrl_d = in_ctrl;
                        m_data_d = in_data;
                     end else if (in_fire) begin
                        s_ctrl_d = in_ctrl;
                        s_data_d = in_data;
                        state_d  = ST_SKID;
                     end else if (out_fire) begin
                        m_ctrl_d = '0;
                        state_d  = ST_EMPTY;
                     end
                  end
                  ST_SKID: begin
                     // in_ready is low here, so only the drain path exists
                     if (out_fire) begin
                        m_ctrl_d = s_ctrl_q;
                        m_data_d = s_data_q;
                        s_ctrl_d = '0;
                        state_d  = ST_FULL;
                     end
                  end
                  default: begin
                     state_d  = ST_EMPTY;
                     m_ctrl_d = '0;
                     s_ctrl_d = '0;
                  end
               endcase
            end
         end

         // NOTE: the data slots are reset too, because out_data must read zero
         // after reset rather than whatever the flops powered up with.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               state_q    <= ST_EMPTY;
               m_ctrl_q   <= '0;
               m_data_q   <= '0;
               s_ctrl_q   <= '0;
               s_data_q   <= '0;
               in_ready_q <= 1'b1;
            end else begin
               state_q    <= state_d;
               m_ctrl_q   <= m_ctrl_d;
               m_data_q   <= m_data_d;
               s_ctrl_q   <= s_ctrl_d;
               s_data_q   <= s_data_d;
               in_ready_q <= (state_d != ST_SKID);
            end
         end

         assign m_valid  = (state_q == ST_FULL) || (state_q == ST_SKID);
         assign m_ctrl   = m_ctrl_q;
         assign m_data   = m_data_q;
         assign in_ready = in_ready_q;
      end else begin : g_single
         logic [1:0]        state_q;
         logic [CTRL_W-1:0] m_ctrl_q;
         logic [DATA_W-1:0] m_data_q;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               state_q  <= ST_EMPTY;
               m_ctrl_q <= '0;
               m_data_q <= '0;
            end else if (flush) begin
               state_q  <= ST_EMPTY;
               m_ctrl_q <= '0;
            end else if (in_fire) begin
               state_q  <= ST_FULL;
               m_ctrl_q <= in_ctrl;
               m_data_q <= in_data;
            end else if (out_fire) begin
               state_q  <= ST_EMPTY;
               m_ctrl_q <= '0;
            end
         end

         assign m_valid  = (state_q == ST_FULL);
         assign m_ctrl   = m_ctrl_q;
         assign m_data   = m_data_q;
         assign in_ready = !m_valid || out_ready;
      end
   endgenerate

   pipe_sat_counter #(
      .CNT_W (CNT_W)
   ) u_stall_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (m_valid & ~out_ready & ~flush),
      .clr   (stall_clr),
      .count (stall_cnt)
   );

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Drives a skid instance (CNT_W=4) and a single-register instance from the same
// inputs and compares both against queue-based reference models.
module tb_pipe_stage_elastic;
   import pipe_pkg::*;

   localparam int DW = 133;
   localparam int CW = 4;

   typedef struct packed {
      logic [CW-1:0] ctrl;
      logic [DW-1:0] data;
   } beat_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic [CW-1:0] in_ctrl;
   logic [DW-1:0] in_data;
   logic          flush;
   logic          out_ready;
   logic          stall_clr;

   logic          rdy_s, ov_s, rdy_f, ov_f;
   logic [CW-1:0] oc_s, oc_f;
   logic [DW-1:0] od_s, od_f;
   logic [3:0]    sc_s;
   logic [15:0]   sc_f;

   beat_t q_s[$];
   beat_t q_f[$];
   int    cnt_s, cnt_f;
   int    n_cmp = 0;
   int    n_bad = 0;

   always #5 clk = ~clk;

   pipe_stage_elastic #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .CNT_W(4)) u_skid (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_s),
      .in_ctrl(in_ctrl), .in_data(in_data), .flush(flush), .out_valid(ov_s),
      .out_ready(out_ready), .out_ctrl(oc_s), .out_data(od_s),
      .stall_cnt(sc_s), .stall_clr(stall_clr)
   );

   pipe_stage_elastic #(.DATA_W(DW), .CTRL_W(CW), .SKID(0), .CNT_W(16)) u_flop (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_f),
      .in_ctrl(in_ctrl), .in_data(in_data), .flush(flush), .out_valid(ov_f),
      .out_ready(out_ready), .out_ctrl(oc_f), .out_data(od_f),
      .stall_cnt(sc_f), .stall_clr(stall_clr)
   );

   task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [DW-1:0] rand_data();
      logic [DW-1:0] d = '0;
      for (int i = 0; i < 5; i++) d = (d << 32) | DW'($urandom);
      return d;
   endfunction

   // Skid stage holds up to two beats and accepts while it holds fewer than two;
   // the single register holds one and accepts when empty or draining.
   task automatic check_outputs();
      int ns = q_s.size();
      int nf = q_f.size();
      check("skid.in_ready", DW'(rdy_s), DW'(ns < 2));
      check("skid.out_valid", DW'(ov_s), DW'(ns > 0));
      check("skid.out_ctrl", DW'(oc_s), DW'(ns > 0 ? q_s[0].ctrl : 4'h0));
      if (ns > 0) check("skid.out_data", od_s, q_s[0].data);
      check("skid.stall_cnt", DW'(sc_s), DW'(cnt_s));
      check("flop.in_ready", DW'(rdy_f), DW'(nf == 0 || out_ready));
      check("flop.out_valid", DW'(ov_f), DW'(nf > 0));
      check("flop.out_ctrl", DW'(oc_f), DW'(nf > 0 ? q_f[0].ctrl : 4'h0));
      if (nf > 0) check("flop.out_data", od_f, q_f[0].data);
      check("flop.stall_cnt", DW'(sc_f), DW'(cnt_f));
   endtask

   task automatic check_reset(input string tag);
      check({tag, ".skid.out_valid"}, DW'(ov_s), '0);
      check({tag, ".skid.out_ctrl"}, DW'(oc_s), '0);
      check({tag, ".skid.out_data"}, od_s, '0);
      check({tag, ".skid.in_ready"}, DW'(rdy_s), DW'(1));
      check({tag, ".skid.stall_cnt"}, DW'(sc_s), '0);
      check({tag, ".flop.out_valid"}, DW'(ov_f), '0);
      check({tag, ".flop.out_ctrl"}, DW'(oc_f), '0);
      check({tag, ".flop.out_data"}, od_f, '0);
      check({tag, ".flop.stall_cnt"}, DW'(sc_f), '0);
   endtask

   task automatic model_reset();
      q_s.delete();
      q_f.delete();
      cnt_s = 0;
      cnt_f = 0;
   endtask

   task automatic model_tick();
      bit    acc_s = (q_s.size() < 2);
      bit    acc_f = (q_f.size() == 0) || out_ready;
      beat_t b;
      b.ctrl = in_ctrl;
      b.data = in_data;
      if (stall_clr) cnt_s = 0;
      else if (q_s.size() > 0 && !out_ready && !flush && cnt_s < 15) cnt_s++;
      if (stall_clr) cnt_f = 0;
      else if (q_f.size() > 0 && !out_ready && !flush && cnt_f < 65535) cnt_f++;
      if (flush) begin
         q_s.delete();
         q_f.delete();
      end else begin
         if (q_s.size() > 0 && out_ready) void'(q_s.pop_front());
         if (in_valid && acc_s) q_s.push_back(b);
         if (q_f.size() > 0 && out_ready) void'(q_f.pop_front());
         if (in_valid && acc_f) q_f.push_back(b);
      end
   endtask

   // Called at a falling edge; returns at the next falling edge.
   task automatic cycle(input logic iv, input logic [CW-1:0] ic, input logic [DW-1:0] id,
                        input logic fl, input logic ordy, input logic clr);
      in_valid  = iv;
      in_ctrl   = ic;
      in_data   = id;
      flush     = fl;
      out_ready = ordy;
      stall_clr = clr;
      #1;
      check_outputs();
      @(posedge clk);
      model_tick();
      @(negedge clk);
   endtask

   initial begin
      logic [DW-1:0] a, b, c;
      exmem_t        e;

      rst_n     = 1'b0;
      in_valid  = 1'b1;
      in_ctrl   = 4'hF;
      in_data   = rand_data();
      flush     = 1'b0;
      out_ready = 1'b1;
      stall_clr = 1'b0;
      model_reset();

      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         check_reset("rst_hold");
         @(negedge clk);
      end
      rst_n = 1'b1;

      // first beat: one cycle from acceptance to out_valid
      cycle(1'b1, 4'hF, rand_data(), 1'b0, 1'b1, 1'b0);
      cycle(1'b0, 4'h0, '0, 1'b0, 1'b1, 1'b0);
      cycle(1'b0, 4'h0, '0, 1'b0, 1'b1, 1'b0);

      // full-throughput stream
      for (int n = 1; n <= 8; n++) cycle(1'b1, 4'b1000, DW'(n), 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) cycle(1'b0, 4'h0, '0, 1'b0, 1'b1, 1'b0);

      // skid fill: A, B, C offered while downstream stalls
      e = '{alu_result: 32'hAAAA_0001, write_data: 32'h1, imm_ext: 32'h2, pc_plus4: 32'h4, rd: 5'd1};
      a = pack_exmem(e);
      e.alu_result = 32'hBBBB_0002; e.rd = 5'd2;
      b = pack_exmem(e);
      e.alu_result = 32'hCCCC_0003; e.rd = 5'd3;
      c = pack_exmem(e);
      cycle(1'b1, 4'b1000, a, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 4'b1000, b, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 4'b1000, c, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 4'b1000, c, 1'b0, 1'b0, 1'b0);
      check("skid_fill.stall_cnt", DW'(sc_s), DW'(3));
      check("skid_fill.in_ready", DW'(rdy_s), '0);
      check("skid_fill.head", od_s, a);
      for (int i = 0; i < 3; i++) cycle(1'b1, 4'b1000, c, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) cycle(1'b0, 4'h0, '0, 1'b0, 1'b1, 1'b0);

      // flush with both slots occupied and C offered
      cycle(1'b0, 4'h0, '0, 1'b0, 1'b1, 1'b1);
      cycle(1'b1, 4'b1001, a, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 4'b1001, b, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 4'b1001, c, 1'b1, 1'b0, 1'b0);
      check("flush.out_valid", DW'(ov_s), '0);
      check("flush.out_ctrl", DW'(oc_s), '0);
      check("flush.in_ready", DW'(rdy_s), DW'(1));
      for (int i = 0; i < 3; i++) cycle(1'b0, 4'h0, '0, 1'b0, 1'b1, 1'b0);

      // stall counter saturation and clear-over-increment
      cycle(1'b1, 4'b0100, rand_data(), 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 21; i++) cycle(1'b1, 4'b0100, rand_data(), 1'b0, 1'b0, 1'b0);
      check("sat.stall_cnt", DW'(sc_s), DW'(4'hF));
      cycle(1'b0, 4'h0, '0, 1'b0, 1'b0, 1'b1);
      check("sat.clr", DW'(sc_s), '0);
      for (int i = 0; i < 4; i++) cycle(1'b0, 4'h0, '0, 1'b0, 1'b1, 1'b0);

      // asynchronous reset while the skid slot is occupied
      cycle(1'b1, 4'b1010, a, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 4'b1010, b, 1'b0, 1'b0, 1'b0);
      check("pre_rst.skid_ready", DW'(rdy_s), '0);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset("async_rst");
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      cycle(1'b0, 4'h0, '0, 1'b0, 1'b1, 1'b0);
      cycle(1'b1, 4'b1000, c, 1'b0, 1'b1, 1'b0);
      cycle(1'b0, 4'h0, '0, 1'b0, 1'b1, 1'b0);

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         cycle(1'($urandom_range(0, 3) != 0), 4'($urandom), rand_data(),
               1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 9) < 7),
               1'($urandom_range(0, 31) == 0));
      end
      for (int i = 0; i < 4; i++) cycle(1'b0, 4'h0, '0, 1'b0, 1'b1, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
